// File: rtl/jump_irq_ctrl_if.sv
// Button/CPU side bundle of the jump interrupt controller.
// The master drives the button and acknowledge; the slave (controller) drives the status outputs.
interface jump_irq_ctrl_if;
  localparam int unsigned CNT_W = 8;

  logic             jump;
  logic             int_ack;
  logic             frame_tick;
  logic             jump_pulse;
  logic             jump_irq;
  logic             jump_level;
  logic [CNT_W-1:0] missed_cnt;

  modport master (
    output jump, int_ack,
    input  frame_tick, jump_pulse, jump_irq, jump_level, missed_cnt
  );

  modport slave (
    input  jump, int_ack,
    output frame_tick, jump_pulse, jump_irq, jump_level, missed_cnt
  );
endinterface

// File: rtl/jump_irq_ctrl.sv
// Jump button synchronizer/debouncer, frame-rate enable and frame-aligned level interrupt
// with a saturating count of presses that merged into an already-pending event.
module jump_irq_ctrl #(
  parameter int unsigned SYSTEM_FREQ     = 100000000,
  parameter int unsigned GAME_FRAME_RT   = 60,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic            clk,
  input logic            reset,
  jump_irq_ctrl_if.slave bus
);

  localparam int unsigned FRAME_DIV = SYSTEM_FREQ / GAME_FRAME_RT;
  localparam int unsigned FC_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned CNT_W     = 8;

  localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(FRAME_DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             pulse_q, pulse_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             latched_q, latched_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] missed_q, missed_d;
  logic             frame_tick_c;
  logic             miss_inc_c;

  assign frame_tick_c = (frame_cnt_q == FC_MAX);

  // Next-state logic for synchronizer, debouncer, frame counter and interrupt delivery.
  always_comb begin
    s1_d        = bus.jump;
    s2_d        = s1_q;
    stable_d    = stable_q;
    db_cnt_d    = db_cnt_q;
    frame_cnt_d = frame_tick_c ? '0 : frame_cnt_q + FC_W'(1);
    latched_d   = latched_q;
    irq_d       = irq_q;
    missed_d    = missed_q;
    miss_inc_c  = 1'b0;

    if (s2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      stable_d = s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    pulse_d = stable_d & ~stable_q;

    // A frame boundary delivers the pending event; a press in that same cycle stays pending.
    if (frame_tick_c && latched_q) begin
      irq_d      = 1'b1;
      latched_d  = pulse_q;
      miss_inc_c = irq_q & ~bus.int_ack;
    end else begin
      if (bus.int_ack) begin
        irq_d = 1'b0;
      end
      if (pulse_q) begin
        latched_d  = 1'b1;
        miss_inc_c = latched_q;
      end
    end

    if (miss_inc_c && (missed_q != CNT_SAT)) begin
      missed_d = missed_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      stable_q    <= 1'b0;
      db_cnt_q    <= '0;
      pulse_q     <= 1'b0;
      frame_cnt_q <= '0;
      latched_q   <= 1'b0;
      irq_q       <= 1'b0;
      missed_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      pulse_q     <= pulse_d;
      frame_cnt_q <= frame_cnt_d;
      latched_q   <= latched_d;
      irq_q       <= irq_d;
      missed_q    <= missed_d;
    end
  end

  assign bus.frame_tick = frame_tick_c;
  assign bus.jump_pulse = pulse_q;
  assign bus.jump_irq   = irq_q;
  assign bus.jump_level = stable_q;
  assign bus.missed_cnt = missed_q;

endmodule
